// File: rtl/dmem_sram_if.sv
// Data-side SRAM request/response bundle between the MEM stage and the responder.
// master = initiator (MEM stage), slave = dmem_sram_responder.
interface dmem_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [1:0]  data_sram_rlen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_stall;
    logic        data_sram_err;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_rlen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_stall,
        input  data_sram_err
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_rlen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_stall,
        output data_sram_err
    );
endinterface

// File: rtl/dmem_sram_responder.sv
// Data SRAM responder: one request at a time, WAIT_CYCLES wait states, owns the RAM.
// Ports: clk, resetn (sync, active-low), bus (dmem_sram_if.slave). Option: DMEM_ERR_CHECK_EN.
module dmem_sram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    dmem_sram_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   accept, commit;

    logic [ADDR_WIDTH-1:0]  idx_q;
    logic [3:0]             wen_q;
    logic [31:0]            wdata_q;
    logic [1:0]             rlen_q;
    logic [31:0]            rdata_q;
    logic                   wr_ok;

    logic [31:0]            mem [2**ADDR_WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.data_sram_en) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            // en still shows the finished request here; never re-accept it
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'd0;
            rlen_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= bus.data_sram_addr[ADDR_WIDTH+1:2];
                wen_q   <= bus.data_sram_wen;
                wdata_q <= bus.data_sram_wdata;
                rlen_q  <= bus.data_sram_rlen;
            end
            if (commit && wen_q == 4'd0) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // RAM is not reset, but a reset on the commit edge must block the write
    always_ff @(posedge clk) begin
        if (resetn && commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic wen_ok;
    logic bad_d;
    logic bad_q;

    always_comb begin
        wen_ok = 1'b0;
        unique case (bus.data_sram_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_ok = 1'b1;
            default:                            wen_ok = 1'b0;
        endcase
    end

    always_comb begin
        bad_d = !wen_ok;
        if (bus.data_sram_wen == 4'd0) begin
            unique case (1'b1)
                bus.data_sram_rlen == 2'd3:
                    bad_d = 1'b1;
                bus.data_sram_rlen == 2'd1:
                    bad_d = bus.data_sram_addr[0];
                bus.data_sram_rlen == 2'd2:
                    bad_d = |bus.data_sram_addr[1:0];
                default:
                    bad_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bad_q <= 1'b0;
        end else if (accept) begin
            bad_q <= bad_d;
        end
    end

    assign bus.data_sram_err = (state_q == DONE) && bad_q;
    assign wr_ok             = !bad_q;
`else
    assign bus.data_sram_err = 1'b0;
    assign wr_ok             = 1'b1;
`endif

    assign bus.data_sram_stall = (state_q == IDLE && bus.data_sram_en)
                               || state_q == BUSY;
    assign bus.data_sram_rdata = rdata_q;

    // upper address bits and read size carry no meaning for the array
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_addr[31:ADDR_WIDTH+2],
                           bus.data_sram_addr[1:0],
                           bus.data_sram_rlen, rlen_q};

endmodule
